// File: rtl/mult_div_unit_pkg.sv
// Shared constants, opcode encodings and FSM state type for the iterative
// signed multiply/divide unit.
package mult_div_unit_pkg;

    localparam int DATA_W = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply / 32/32 divide: sign-magnitude shift-add and
// restoring-subtract over 64-bit working registers, signs restored on entry to DONE.
module mult_div_unit #(
    parameter int DATA_W = mult_div_unit_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic              busy,
    output logic              done,
    output logic              div_zero
);
    import mult_div_unit_pkg::*;

    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [2*DATA_W-1:0] work_q, work_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                div_zero_q, div_zero_d;

    logic [DATA_W:0]     mult_sum;
    logic [2*DATA_W-1:0] mult_next;
    logic [2*DATA_W-1:0] mult_fix;
    logic                div_ge;
    logic [DATA_W-1:0]   div_diff;
    logic [2*DATA_W-1:0] div_next;

    // One shift-add step: low half holds the remaining multiplier bits.
    assign mult_sum  = {1'b0, work_q[2*DATA_W-1:DATA_W]}
                     + (work_q[0] ? {1'b0, opb_q} : '0);
    assign mult_next = {mult_sum, work_q[DATA_W-1:1]};
    assign mult_fix  = neg_res_q ? (~mult_next + 1'b1) : mult_next;

    // One restoring step: the partial remainder is always below the divisor,
    // so after the difference it fits back into the upper half.
    assign div_ge    = work_q[2*DATA_W-1:DATA_W-1] >= {1'b0, opb_q};
    assign div_diff  = work_q[2*DATA_W-2:DATA_W-1] - opb_q;
    assign div_next  = {(div_ge ? div_diff : work_q[2*DATA_W-2:DATA_W-1]),
                        work_q[DATA_W-2:0], div_ge};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        opb_d      = opb_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d     = '0;
                    work_d    = {{DATA_W{1'b0}}, abs_val(a_in)};
                    opb_d     = abs_val(b_in);
                    neg_res_d = a_in[DATA_W-1] ^ b_in[DATA_W-1];
                    neg_rem_d = a_in[DATA_W-1];
                    if (op == OP_MULT) begin
                        state_d = ST_MULT;
                    end else if (b_in == '0) begin
                        div_zero_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MULT: begin
                work_d = mult_next;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_DONE;
                    hi_d    = mult_fix[2*DATA_W-1:DATA_W];
                    lo_d    = mult_fix[DATA_W-1:0];
                end
            end
            ST_DIV: begin
                work_d = div_next;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_DONE;
                    hi_d    = neg_rem_q ? (~div_next[2*DATA_W-1:DATA_W] + 1'b1)
                                        : div_next[2*DATA_W-1:DATA_W];
                    lo_d    = neg_res_q ? (~div_next[DATA_W-1:0] + 1'b1)
                                        : div_next[DATA_W-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            work_q     <= '0;
            opb_q      <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            opb_q      <= opb_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign busy     = (state_q == ST_MULT) || (state_q == ST_DIV);
    assign done     = (state_q == ST_DONE);
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed vector bench for mult_div_unit: table of hand-computed results plus
// hand-written sequences for divide-by-zero, ignored start and mid-op reset.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a_in, b_in;
    logic [31:0] hi_out, lo_out;
    logic        busy, done, div_zero;

    int checks = 0;
    int errors = 0;

    mult_div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation; returns cycle index of done (0 on timeout) and
    // the outputs seen in that cycle. Inputs are scrambled right after sampling.
    task automatic run_op(input logic op_v, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] hi, output logic [31:0] lo,
                          output logic dz);
        lat = 0; hi = '0; lo = '0; dz = 1'b0;
        @(negedge clk);
        op = op_v; a_in = a; b_in = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = ~op_v; a_in = 32'hDEAD_BEEF; b_in = 32'h0;
        for (int n = 1; n <= 60; n++) begin
            if (n > 1) begin
                @(posedge clk);
                #1;
            end
            if (done) begin
                lat = n; hi = hi_out; lo = lo_out; dz = div_zero;
                break;
            end
            if (div_zero) begin
                checks++; errors++;
                $display("FAIL div_zero_without_done: got 1 expected 0 at cycle %0d", n);
            end
        end
        @(posedge clk);
        #1;
    endtask

    int          lat;
    logic [31:0] hi, lo;
    logic        dz;
    int          done_cnt, done_at;

    initial begin
        vecs[0]  = '{1'b0, 32'd6,         32'd7,         32'h0000_0000, 32'h0000_002A, 1'b0, 33};
        vecs[1]  = '{1'b0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33};
        vecs[2]  = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 33};
        vecs[3]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33};
        vecs[4]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 33};
        vecs[5]  = '{1'b0, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33};
        vecs[6]  = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
        vecs[7]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33};
        vecs[8]  = '{1'b1, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, 33};
        vecs[9]  = '{1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 33};
        vecs[10] = '{1'b1, 32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0, 33};
        vecs[11] = '{1'b1, 32'd3,         32'd5,         32'h0000_0003, 32'h0000_0000, 1'b0, 33};

        reset = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi", {32'h0, hi_out}, 64'h0);
        chk("reset_lo", {32'h0, lo_out}, 64'h0);
        chk("reset_flags", {61'h0, busy, done, div_zero}, 64'h0);

        // Reset must win over a simultaneous start.
        @(negedge clk);
        start = 1'b1; op = 1'b0; a_in = 32'd9; b_in = 32'd9;
        @(posedge clk);
        #1;
        chk("reset_priority_busy", {63'h0, busy}, 64'h0);
        @(negedge clk);
        start = 1'b0; reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, hi, lo, dz);
            $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d lat=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, dz, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_hi", i), {32'h0, hi}, {32'h0, vecs[i].exp_hi});
            chk($sformatf("vec%0d_lo", i), {32'h0, lo}, {32'h0, vecs[i].exp_lo});
            chk($sformatf("vec%0d_div_zero", i), {63'h0, dz}, {63'h0, vecs[i].exp_dz});
            chk($sformatf("vec%0d_done_cleared", i), {62'h0, done, div_zero}, 64'h0);
        end

        // Divide by zero leaves the previous result (0x11 / 0x22) in place.
        run_op(1'b1, 32'h451, 32'h20, lat, hi, lo, dz);
        $display("setup div 451/20 -> hi=%h lo=%h lat=%0d", hi, lo, lat);
        chk("dz_setup_result", {hi, lo}, {32'h11, 32'h22});
        run_op(1'b1, 32'd5, 32'd0, lat, hi, lo, dz);
        $display("div 5/0 -> hi=%h lo=%h dz=%0d lat=%0d", hi, lo, dz, lat);
        chk("dz_latency", 64'(lat), 64'd1);
        chk("dz_flag", {63'h0, dz}, 64'h1);
        chk("dz_hold_result", {hi, lo}, {32'h11, 32'h22});
        chk("dz_flag_cleared", {63'h0, div_zero}, 64'h0);

        // A second start while busy is ignored.
        @(negedge clk);
        start = 1'b1; op = 1'b0; a_in = 32'd3; b_in = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_cnt = 0; done_at = 0;
        for (int n = 1; n <= 45; n++) begin
            if (n > 1) begin
                @(posedge clk);
                #1;
            end
            if (n == 10) begin
                start = 1'b1; op = 1'b1; a_in = 32'd70; b_in = 32'd7;
            end
            if (n == 11) start = 1'b0;
            if (n == 34) start = 1'b1;
            if (n == 35) start = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
                if (n == 33) lo = lo_out;
            end
        end
        $display("mult 3x3 with restarts -> done_cnt=%0d done_at=%0d lo=%h", done_cnt, done_at, lo);
        chk("ignore_start_done_at", 64'(done_at), 64'd33);
        chk("ignore_start_lo", {32'h0, lo}, 64'd9);
        chk("ignore_start_done_cnt", 64'(done_cnt), 64'd1);
        repeat (40) @(posedge clk);
        #1;
        op = 1'b0;

        // Reset in the middle of a divide aborts it silently.
        @(negedge clk);
        start = 1'b1; op = 1'b1; a_in = 32'h1234_5678; b_in = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midreset_outputs", {hi_out, lo_out}, 64'h0);
        chk("midreset_flags", {61'h0, busy, done, div_zero}, 64'h0);
        done_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        chk("midreset_no_done", 64'(done_cnt), 64'd0);
        run_op(1'b0, 32'd2, 32'd2, lat, hi, lo, dz);
        $display("mult 2x2 after reset -> hi=%h lo=%h lat=%0d", hi, lo, lat);
        chk("post_reset_latency", 64'(lat), 64'd33);
        chk("post_reset_result", {hi, lo}, {32'h0, 32'h4});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
